// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice.
// Holds the opcode encodings, the 13-bit one-hot ALU select constants,
// the sequencer state enum, the latency class enum and the default
// multi-cycle latencies. No ports (package).
package alu_pkg;

    localparam int OP_W   = 5;
    localparam int CTRL_W = 13;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_AND  = 5'd0;
    localparam logic [OP_W-1:0] OP_OR   = 5'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 5'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd3;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd4;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 5'd6;
    localparam logic [OP_W-1:0] OP_SHRA = 5'd7;
    localparam logic [OP_W-1:0] OP_SHL  = 5'd8;
    localparam logic [OP_W-1:0] OP_ROR  = 5'd9;
    localparam logic [OP_W-1:0] OP_ROL  = 5'd10;
    localparam logic [OP_W-1:0] OP_NEG  = 5'd11;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd12;

    localparam logic [CTRL_W-1:0] CTRL_NONE = 13'h0000;
    localparam logic [CTRL_W-1:0] CTRL_AND  = 13'h0001;
    localparam logic [CTRL_W-1:0] CTRL_OR   = 13'h0002;
    localparam logic [CTRL_W-1:0] CTRL_ADD  = 13'h0004;
    localparam logic [CTRL_W-1:0] CTRL_SUB  = 13'h0008;
    localparam logic [CTRL_W-1:0] CTRL_MUL  = 13'h0010;
    localparam logic [CTRL_W-1:0] CTRL_DIV  = 13'h0020;
    localparam logic [CTRL_W-1:0] CTRL_SHR  = 13'h0040;
    localparam logic [CTRL_W-1:0] CTRL_SHRA = 13'h0080;
    localparam logic [CTRL_W-1:0] CTRL_SHL  = 13'h0100;
    localparam logic [CTRL_W-1:0] CTRL_ROR  = 13'h0200;
    localparam logic [CTRL_W-1:0] CTRL_ROL  = 13'h0400;
    localparam logic [CTRL_W-1:0] CTRL_NEG  = 13'h0800;
    localparam logic [CTRL_W-1:0] CTRL_NOT  = 13'h1000;

    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_DIV_LAT = 34;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        LAT_ONE = 2'd0,
        LAT_MUL = 2'd1,
        LAT_DIV = 2'd2
    } lat_class_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder.
// Ports:
//   opcode    in  5   operation code
//   control   out 13  one-hot ALU select (zero for illegal opcodes)
//   legal     out 1   opcode is 0..12
//   lat_class out 2   latency class (single-cycle, MUL or DIV)
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    output logic [CTRL_W-1:0] control,
    output logic              legal,
    output lat_class_e        lat_class
);

    // Map opcode to one-hot select, legality and latency class.
    always_comb begin
        control   = CTRL_NONE;
        legal     = 1'b1;
        lat_class = LAT_ONE;
        case (opcode)
            OP_AND:  control = CTRL_AND;
            OP_OR:   control = CTRL_OR;
            OP_ADD:  control = CTRL_ADD;
            OP_SUB:  control = CTRL_SUB;
            OP_MUL: begin
                control   = CTRL_MUL;
                lat_class = LAT_MUL;
            end
            OP_DIV: begin
                control   = CTRL_DIV;
                lat_class = LAT_DIV;
            end
            OP_SHR:  control = CTRL_SHR;
            OP_SHRA: control = CTRL_SHRA;
            OP_SHL:  control = CTRL_SHL;
            OP_ROR:  control = CTRL_ROR;
            OP_ROL:  control = CTRL_ROL;
            OP_NEG:  control = CTRL_NEG;
            OP_NOT:  control = CTRL_NOT;
            default: begin
                control = CTRL_NONE;
                legal   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time: accepts an opcode and operands,
// drives registered operands and a one-hot select to an external ALU for
// the operation's execute cycle count, then captures the 64-bit result.
// Configuration macro: ALU_SEQ_MULTICYCLE_EN -- when defined, MUL holds
// EXEC for MUL_LAT cycles and DIV for DIV_LAT cycles; otherwise every
// legal opcode executes in one cycle.
// Ports:
//   clk, clr_n            clock, async active-low reset
//   op_valid/op_ready     request handshake
//   opcode, a_in, b_in    request payload
//   alu_a, alu_b          registered operands to the ALU
//   alu_control           one-hot ALU select (zero outside EXEC)
//   alu_c                 ALU result
//   zhi, zlo              captured result
//   z_valid               one-cycle pulse on new result
//   illegal               one-cycle pulse on rejected opcode
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [OP_W-1:0]     opcode,
    input  logic [DATA_W-1:0]   a_in,
    input  logic [DATA_W-1:0]   b_in,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [CTRL_W-1:0]   alu_control,
    input  logic [2*DATA_W-1:0] alu_c,
    output logic [DATA_W-1:0]   zhi,
    output logic [DATA_W-1:0]   zlo,
    output logic                z_valid,
    output logic                illegal
);

    localparam int CNT_W = 32;
    // Counter holds "cycles remaining minus one"; latencies below 1 clamp to 1.
    localparam logic [CNT_W-1:0] MUL_CNT = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DIV_CNT = (DIV_LAT > 1) ? CNT_W'(DIV_LAT - 1) : {CNT_W{1'b0}};
`ifdef ALU_SEQ_MULTICYCLE_EN
    localparam bit MC_EN = 1'b1;
`else
    localparam bit MC_EN = 1'b0;
`endif

    seq_state_e        state_r;
    seq_state_e        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_load_s;
    logic [OP_W-1:0]   opc_r;
    logic [OP_W-1:0]   dec_op_s;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] zhi_r;
    logic [DATA_W-1:0] zlo_r;
    logic [CTRL_W-1:0] ctrl_s;
    logic              legal_s;
    lat_class_e        lat_class_s;
    logic              accept_s;
    logic              start_s;
    logic              capture_s;
    logic              op_ready_r;
    logic              op_ready_nxt_s;
    logic [CTRL_W-1:0] alu_control_r;
    logic [CTRL_W-1:0] alu_control_nxt_s;
    logic              z_valid_r;
    logic              z_valid_nxt_s;
    logic              illegal_r;
    logic              illegal_nxt_s;

    // Decode the incoming opcode in IDLE, the latched one otherwise.
    always_comb begin
        if (state_r == ST_IDLE) begin
            dec_op_s = opcode;
        end else begin
            dec_op_s = opc_r;
        end
    end

    alu_op_decode u_decode (
        .opcode    (dec_op_s),
        .control   (ctrl_s),
        .legal     (legal_s),
        .lat_class (lat_class_s)
    );

    assign accept_s  = (state_r == ST_IDLE) && op_valid;
    assign start_s   = accept_s && legal_s;
    assign capture_s = (state_r == ST_EXEC) && (cnt_r == {CNT_W{1'b0}});

    // Select the counter preload from the latency class.
    always_comb begin
        cnt_load_s = {CNT_W{1'b0}};
        case (lat_class_s)
            LAT_MUL: cnt_load_s = MC_EN ? MUL_CNT : {CNT_W{1'b0}};
            LAT_DIV: cnt_load_s = MC_EN ? DIV_CNT : {CNT_W{1'b0}};
            default: cnt_load_s = {CNT_W{1'b0}};
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (capture_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic, computed from the next state so the outputs can be registered.
    always_comb begin
        op_ready_nxt_s    = (state_nxt_s == ST_IDLE);
        z_valid_nxt_s     = (state_nxt_s == ST_DONE);
        illegal_nxt_s     = accept_s && !legal_s;
        alu_control_nxt_s = CTRL_NONE;
        if (state_nxt_s == ST_EXEC) begin
            alu_control_nxt_s = ctrl_s;
        end else begin
            alu_control_nxt_s = CTRL_NONE;
        end
    end

    // Output registers; op_ready comes out of reset high.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            op_ready_r    <= 1'b1;
            z_valid_r     <= 1'b0;
            illegal_r     <= 1'b0;
            alu_control_r <= CTRL_NONE;
        end else begin
            op_ready_r    <= op_ready_nxt_s;
            z_valid_r     <= z_valid_nxt_s;
            illegal_r     <= illegal_nxt_s;
            alu_control_r <= alu_control_nxt_s;
        end
    end

    // Operand/opcode latch, cycle counter and result capture.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_r   <= {DATA_W{1'b0}};
            b_r   <= {DATA_W{1'b0}};
            opc_r <= {OP_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            zhi_r <= {DATA_W{1'b0}};
            zlo_r <= {DATA_W{1'b0}};
        end else begin
            if (start_s) begin
                a_r   <= a_in;
                b_r   <= b_in;
                opc_r <= opcode;
                cnt_r <= cnt_load_s;
            end else if (capture_s) begin
                zhi_r <= alu_c[2*DATA_W-1:DATA_W];
                zlo_r <= alu_c[DATA_W-1:0];
            end else if (state_r == ST_EXEC) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign op_ready    = op_ready_r;
    assign z_valid     = z_valid_r;
    assign illegal     = illegal_r;
    assign alu_control = alu_control_r;
    assign alu_a       = a_r;
    assign alu_b       = b_r;
    assign zhi         = zhi_r;
    assign zlo         = zlo_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU
// attached to alu_a/alu_b/alu_control/alu_c.
module tb_alu_sequencer;

`ifdef ALU_SEQ_MULTICYCLE_EN
    localparam int EXP_MUL_CYC = 4;
    localparam int ABORT_CYC   = 10;
`else
    localparam int EXP_MUL_CYC = 1;
    localparam int ABORT_CYC   = 1;
`endif

    logic        clk = 1'b0;
    logic        clr_n;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  opcode;
    logic [31:0] a_in, b_in;
    logic [31:0] alu_a, alu_b;
    logic [12:0] alu_control;
    logic [63:0] alu_c;
    logic [31:0] zhi, zlo;
    logic        z_valid;
    logic        illegal;

    int tests_run    = 0;
    int tests_failed = 0;
    int zv_cnt       = 0;
    int zv_base;

    alu_sequencer #(.MUL_LAT(4), .DIV_LAT(34)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .opcode      (opcode),
        .a_in        (a_in),
        .b_in        (b_in),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_c       (alu_c),
        .zhi         (zhi),
        .zlo         (zlo),
        .z_valid     (z_valid),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Behavioural team ALU: DIV returns {remainder, quotient}.
    always_comb begin
        alu_c = 64'd0;
        case (alu_control)
            13'h0001: alu_c = {32'd0, alu_a & alu_b};
            13'h0002: alu_c = {32'd0, alu_a | alu_b};
            13'h0004: alu_c = {32'd0, alu_a + alu_b};
            13'h0008: alu_c = {32'd0, alu_a - alu_b};
            13'h0010: alu_c = {32'd0, alu_a} * {32'd0, alu_b};
            13'h0020: alu_c = (alu_b == 32'd0) ? 64'd0 : {alu_a % alu_b, alu_a / alu_b};
            13'h0040: alu_c = {32'd0, alu_a >> alu_b[4:0]};
            13'h0080: alu_c = {32'd0, 32'($signed(alu_a) >>> alu_b[4:0])};
            13'h0100: alu_c = {32'd0, alu_a << alu_b[4:0]};
            13'h0200: alu_c = {32'd0, (alu_a >> alu_b[4:0]) | (alu_a << (6'd32 - {1'b0, alu_b[4:0]}))};
            13'h0400: alu_c = {32'd0, (alu_a << alu_b[4:0]) | (alu_a >> (6'd32 - {1'b0, alu_b[4:0]}))};
            13'h0800: alu_c = {32'd0, 32'd0 - alu_a};
            13'h1000: alu_c = {32'd0, ~alu_a};
            default:  alu_c = 64'd0;
        endcase
    end

    // Count z_valid pulses seen.
    always @(negedge clk) begin
        if (z_valid === 1'b1) zv_cnt <= zv_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One single-cycle op, issued from the current negedge with the sequencer in IDLE.
    task automatic run_single(input string tag, input logic [4:0] opc, input logic [31:0] a,
                              input logic [31:0] b, input logic [63:0] exp_z);
        logic [12:0] exp_ctrl;
        exp_ctrl = 13'd1 << opc;
        op_valid = 1'b1; opcode = opc; a_in = a; b_in = b;
        tick();
        op_valid = 1'b0;
        check_eq({tag, "_ctrl"},  {51'd0, alu_control}, {51'd0, exp_ctrl});
        check_eq({tag, "_rdy0"},  {63'd0, op_ready}, 64'd0);
        check_eq({tag, "_zv0"},   {63'd0, z_valid}, 64'd0);
        tick();
        check_eq({tag, "_zv1"},   {63'd0, z_valid}, 64'd1);
        check_eq({tag, "_z"},     {zhi, zlo}, exp_z);
        check_eq({tag, "_ctrl0"}, {51'd0, alu_control}, 64'd0);
        tick();
        check_eq({tag, "_zv2"},   {63'd0, z_valid}, 64'd0);
        check_eq({tag, "_rdy1"},  {63'd0, op_ready}, 64'd1);
    endtask

    initial begin
        clr_n = 1'b0; op_valid = 1'b0; opcode = 5'd0; a_in = 32'd0; b_in = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_ready", {63'd0, op_ready}, 64'd1);
        check_eq("rst_zv",    {63'd0, z_valid}, 64'd0);
        check_eq("rst_ill",   {63'd0, illegal}, 64'd0);
        check_eq("rst_ctrl",  {51'd0, alu_control}, 64'd0);
        check_eq("rst_z",     {zhi, zlo}, 64'd0);
        check_eq("rst_ab",    {alu_a, alu_b}, 64'd0);

        // Release and transfer on the very first rising edge.
        clr_n = 1'b1;
        run_single("add", 5'd2, 32'd5, 32'd7, 64'd12);
        check_eq("add_ab", {alu_a, alu_b}, {32'd5, 32'd7});
        run_single("shra", 5'd7, 32'h8000_0000, 32'd4, 64'h0000_0000_F800_0000);
        run_single("rol",  5'd10, 32'h8000_0001, 32'd1, 64'h0000_0000_0000_0003);

        // MUL: holds select for the configured execute count.
        op_valid = 1'b1; opcode = 5'd4; a_in = 32'hFFFF_FFFF; b_in = 32'd2;
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < EXP_MUL_CYC; i++) begin
            check_eq("mul_ctrl", {51'd0, alu_control}, 64'h10);
            check_eq("mul_zv0",  {63'd0, z_valid}, 64'd0);
            tick();
        end
        check_eq("mul_zv1",  {63'd0, z_valid}, 64'd1);
        check_eq("mul_z",    {zhi, zlo}, 64'h0000_0001_FFFF_FFFE);
        check_eq("mul_ctrl0", {51'd0, alu_control}, 64'd0);
        tick();
        check_eq("mul_rdy", {63'd0, op_ready}, 64'd1);

        // Illegal opcodes 20 and 13: rejected, nothing else changes.
        op_valid = 1'b1; opcode = 5'd20; a_in = 32'hDEAD_BEEF; b_in = 32'h1234_5678;
        tick();
        op_valid = 1'b0;
        check_eq("ill20_pulse", {63'd0, illegal}, 64'd1);
        check_eq("ill20_rdy",   {63'd0, op_ready}, 64'd1);
        check_eq("ill20_z",     {zhi, zlo}, 64'h0000_0001_FFFF_FFFE);
        check_eq("ill20_ab",    {alu_a, alu_b}, {32'hFFFF_FFFF, 32'd2});
        check_eq("ill20_ctrl",  {51'd0, alu_control}, 64'd0);
        tick();
        check_eq("ill20_end",   {63'd0, illegal}, 64'd0);
        op_valid = 1'b1; opcode = 5'd13;
        tick();
        op_valid = 1'b0;
        check_eq("ill13_pulse", {63'd0, illegal}, 64'd1);
        check_eq("ill13_zv",    {63'd0, z_valid}, 64'd0);
        tick();
        check_eq("ill13_end",   {63'd0, illegal}, 64'd0);

        // Back-to-back with op_valid held: NOT 0, then SUB 3-5.
        zv_base = zv_cnt;
        op_valid = 1'b1; opcode = 5'd12; a_in = 32'd0; b_in = 32'd0;
        tick();
        opcode = 5'd3; a_in = 32'd3; b_in = 32'd5;
        check_eq("b2b_not_ctrl", {51'd0, alu_control}, 64'h1000);
        tick();
        check_eq("b2b_not_zv",  {63'd0, z_valid}, 64'd1);
        check_eq("b2b_not_z",   {zhi, zlo}, 64'h0000_0000_FFFF_FFFF);
        check_eq("b2b_busy",    {63'd0, op_ready}, 64'd0);
        tick();
        check_eq("b2b_rdy",     {63'd0, op_ready}, 64'd1);
        tick();
        op_valid = 1'b0;
        check_eq("b2b_sub_ctrl", {51'd0, alu_control}, 64'h0008);
        check_eq("b2b_sub_ab",   {alu_a, alu_b}, {32'd3, 32'd5});
        tick();
        check_eq("b2b_sub_zv",  {63'd0, z_valid}, 64'd1);
        check_eq("b2b_sub_z",   {zhi, zlo}, 64'h0000_0000_FFFF_FFFE);
        tick();
        tick();
        check_eq("b2b_pulses",  64'(zv_cnt - zv_base), 64'd2);

        // DIV aborted by reset mid-EXEC.
        op_valid = 1'b1; opcode = 5'd5; a_in = 32'd100; b_in = 32'd7;
        tick();
        op_valid = 1'b0;
        check_eq("div_ctrl", {51'd0, alu_control}, 64'h0020);
        zv_base = zv_cnt;
        for (int i = 1; i < ABORT_CYC; i++) tick();
        clr_n = 1'b0;
        #1;
        check_eq("abort_z",    {zhi, zlo}, 64'd0);
        check_eq("abort_ctrl", {51'd0, alu_control}, 64'd0);
        check_eq("abort_ab",   {alu_a, alu_b}, 64'd0);
        tick();
        tick();
        clr_n = 1'b1;
        check_eq("abort_rdy",  {63'd0, op_ready}, 64'd1);
        check_eq("abort_zv",   {63'd0, z_valid}, 64'd0);
        for (int i = 0; i < 40; i++) tick();
        check_eq("abort_nopulse", 64'(zv_cnt - zv_base), 64'd0);
        check_eq("abort_z_hold", {zhi, zlo}, 64'd0);

        run_single("and", 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
